// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with push, pop, flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;

    // Popping an empty FIFO is a no-op; flush overrides both push and pop.
    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit check must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-cycle in-flight tracking, credit-limited
// request issue and a prefetch FIFO feeding decode through valid/ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    localparam int             CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [CW-1:0]   fifo_count
);

    logic [XLEN-1:0] fetch_pc;
    logic            inflight_p1;
    logic [XLEN-1:0] req_pc_p1;
    logic [CW:0]     credit_used;
    logic            kill;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Stage 0: credit-limited request issue
    assign credit_used    = (CW+1)'(fifo_count) + (CW+1)'(inflight_p1);
    assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr      = fetch_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= imem_req_valid;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (imem_req_valid) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req_valid) begin
            req_pc_p1 <= fetch_pc;
        end
    end

    // Stage 1: response capture; a redirect this cycle kills the returning word
    assign kill             = redirect_valid;
    assign push             = inflight_p1 && !kill;
    assign pop              = if_valid && id_ready && !redirect_valid;
    assign push_entry.pc    = req_pc_p1;
    assign push_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Stage 2: decode-facing head; zeroed when empty so reset state is clean
    assign if_valid = (fifo_count != '0);
    assign if_pc    = if_valid ? head.pc    : '0;
    assign if_instr = if_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rdata_addr = '0;

    logic [31:0] m_pc;
    logic [31:0] m_qpc[$];
    logic        m_inflight;
    logic [31:0] m_inflight_pc;

    fetch_unit #(
        .XLEN       (32),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Synchronous instruction memory: word for the address presented last cycle.
    always @(posedge clk) rdata_addr <= imem_addr;
    assign imem_rdata = mem_word(rdata_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = RST_PC;
        m_qpc.delete();
        m_inflight = 1'b0;
        m_inflight_pc = '0;
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
        e_req   = r && !rv && ((m_qpc.size() + int'(m_inflight)) < DEPTH);
        e_valid = m_qpc.size() > 0;
        e_pc    = e_valid ? m_qpc[0] : 32'h0;
        check("imem_req_valid", 32'(imem_req_valid), 32'(e_req));
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(e_valid));
        check("if_pc", if_pc, e_pc);
        check("if_instr", if_instr, e_valid ? mem_word(e_pc) : 32'h0);
        check("fifo_count", 32'(fifo_count), 32'(m_qpc.size()));
        if (!r) begin
            model_reset();
        end else if (rv) begin
            m_qpc.delete();
            m_inflight = 1'b0;
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (e_valid && rdy) void'(m_qpc.pop_front());
            if (m_inflight) m_qpc.push_back(m_inflight_pc);
            m_inflight = e_req;
            if (e_req) begin
                m_inflight_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
        check("model_credit", 32'(m_qpc.size() + int'(m_inflight) <= DEPTH), 32'd1);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        // reset with a redirect asserted: must be ignored
        cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        // streaming, then backpressure and drain
        run(6, 1'b1);
        run(10, 1'b0);
        run(10, 1'b1);
        // redirect while the FIFO holds entries
        run(3, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0102, 1'b0);
        run(6, 1'b1);
        // redirect concurrent with pop and in-flight response
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        run(5, 1'b1);
        // address wrap-around
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(6, 1'b1);
        // back-to-back redirects
        cycle(1'b1, 1'b1, 32'h0000_0300, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0503, 1'b1);
        run(5, 1'b1);
        // mid-stream reset
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        run(5, 1'b1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 15) == 0),
                  rpc,
                  ($urandom_range(0, 3) != 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF_ID pipeline register. It owns the program counter and issues sequential word fetches to a synchronous instruction memory. It buffers returned instructions with their PCs in a small prefetch FIFO and presents them to decode through a valid/ready handshake. A branch or jump redirect from a later stage flushes the FIFO and all in-flight fetches, then resumes fetching at the target.

Parameters:
XLEN, 32, address and instruction width
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-low reset
imem_req_valid  output  1  fetch request issued this cycle
imem_addr  output  XLEN  word-aligned fetch address
imem_rdata  input  XLEN  instruction word, valid in the cycle after its request
redirect_valid  input  1  control-flow redirect from a downstream stage
redirect_pc  input  XLEN  redirect target
id_ready  input  1  decode accepts the head entry this cycle
if_valid  output  1  FIFO head is valid
if_pc  output  XLEN  PC of the head entry
if_instr  output  XLEN  instruction of the head entry
fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset (rst==0 at a clock edge):
  - fetch_pc <= RESET_PC.
  - FIFO is emptied and the in-flight flag is cleared.
  - if_valid=0, fifo_count=0, imem_req_valid=0.
  - if_pc and if_instr are 0.
  - A redirect during reset is ignored.
- Request issue:
  - imem_req_valid = rst && !redirect_valid && (fifo_count + inflight < FIFO_DEPTH).
  - imem_addr = fetch_pc.
  - When a request issues, fetch_pc <= fetch_pc + 4 (mod 2^XLEN, so 0xFFFF_FFFC wraps to 0).
- Response:
  - The in-flight flag is set in each issuing cycle.
  - In the following cycle, if the flag is set and not killed, {pc, imem_rdata} is pushed at the end of that cycle.
  - Request-to-if_valid latency is 2 cycles.
- Credit rule: fifo_count + inflight never exceeds FIFO_DEPTH, so a push never finds the FIFO full. Overflow is a design error; an assertion is required.
- Handshake:
  - A pop occurs when if_valid && id_ready.
  - If if_valid is high and id_ready is low, if_pc and if_instr hold stable.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop with id_ready high while empty is a no-op.
- Throughput: with id_ready held high, one instruction per cycle in steady state, no bubbles.
- Redirect (redirect_valid==1, rst==1):
  - The FIFO is cleared and any response arriving next cycle is dropped.
  - No request is issued in the redirect cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - The first new request goes out the next cycle.
  - if_valid is 0 for the 2 cycles after the redirect cycle.
- Simultaneous events:
  - Redirect takes priority over push and pop; a concurrent pop handshake is discarded.
  - Back-to-back redirects: the last one wins.
- Ordering: entries leave in strict fetch order; PCs of consecutive entries differ by 4 unless separated by a redirect.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are derived from fifo_count.

Decomposition:
- Shared package fetch_pkg:
  - XLEN constant
  - NOP_INSTR = 32'h0000_0013
  - fetch_entry_t packed struct {pc, instr}
- Natural sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t with push, pop, flush and count.
- fetch_unit keeps the PC register, the in-flight/kill flags and the credit logic.

Test Plan:
- Reset then rst=1 at cycle 0, id_ready=1, imem returns mem[addr] -> requests 0x0,0x4,0x8,... from cycle 0; if_valid at cycle 2 with if_pc=0x0; thereafter one entry per cycle with PC +4.
- Backpressure: id_ready=0 from cycle 2 for 10 cycles -> fifo_count saturates at 4; imem_req_valid falls to 0; if_pc holds at 0x0; after release entries 0x0..0xC drain in order and fetching resumes at 0x10.
- Redirect to 0x0000_0102 while the FIFO holds 3 entries -> next cycle fifo_count=0 and imem_addr=0x100; the stale response is dropped; if_valid rises 2 cycles later with if_pc=0x100.
- Redirect in the same cycle as a pop handshake and an in-flight response -> no entry pushed; fifo_count=0; first valid output is the redirect target.
- Wrap-around: redirect to 0xFFFF_FFF8 -> if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Mid-operation reset: rst=0 for one cycle while streaming -> next cycle if_valid=0, fifo_count=0; fetch restarts at RESET_PC.
